riscv_fetch_req_ctrl: RTL and testbench

Instruction-memory initiator that feeds the fetch FIFO. It generates word-aligned fetch requests on the instruction-memory req/gnt/rvalid interface and tracks granted-but-unanswered transactions. It forwards in-order responses, with their addresses, into the FIFO's input port. On a branch it clears the FIFO, redirects fetching and discards stale in-flight responses.

---
 rtl/riscv_fetch_pkg.sv | 12 +
 rtl/riscv_fetch_addr_queue.sv | 40 ++++
 rtl/riscv_fetch_req_ctrl.sv | 136 +++++++++++++
 tb/tb_riscv_fetch_req_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch request controller.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    REQ_STALE = 2'd2
  } fetch_state_e;

  localparam logic [31:0] FETCH_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/riscv_fetch_addr_queue.sv
// Small in-order queue holding the addresses of granted-but-unanswered fetches.
module riscv_fetch_addr_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [31:0] push_addr,
  input  logic        pop,
  output logic [31:0] head_addr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [0:(2**PW)-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_addr;
  end

  assign head_addr = mem[rd_ptr];

endmodule

// File: rtl/riscv_fetch_req_ctrl.sv
// Fetch request initiator: issues word-aligned instruction-memory requests,
// tracks outstanding transactions and forwards in-order responses to the FIFO.
module riscv_fetch_req_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned RDATA_WIDTH     = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_i,
  input  logic                   branch_i,
  input  logic [31:0]            branch_addr_i,
  input  logic                   fifo_in_ready_i,
  output logic                   fifo_clear_o,
  output logic                   fifo_valid_o,
  output logic [31:0]            fifo_addr_o,
  output logic [RDATA_WIDTH-1:0] fifo_rdata_o,
  output logic                   instr_req_o,
  output logic [31:0]            instr_addr_o,
  input  logic                   instr_gnt_i,
  input  logic                   instr_rvalid_i,
  input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
  output logic                   busy_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_next;
  logic [31:0]   req_addr;
  logic [31:0]   req_addr_next;
  logic [31:0]   head_addr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_after;
  logic [CW-1:0] discard_cnt;
  logic [CW-1:0] discard_next;
  logic          gnt_acc;
  logic          issue;

  assign gnt_acc           = (state != IDLE) && instr_gnt_i;
  assign outstanding_after = outstanding + CW'(gnt_acc) - CW'(instr_rvalid_i);
  assign issue             = req_i && fifo_in_ready_i &&
                             (outstanding_after < CW'(MAX_OUTSTANDING));

  riscv_fetch_addr_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_acc),
    .push_addr (req_addr),
    .pop       (instr_rvalid_i),
    .head_addr (head_addr)
  );

  // A branch overrides the normal progression; a stale request must still see its grant.
  always_comb begin
    state_next    = state;
    req_addr_next = req_addr;
    fetch_next    = fetch_addr;
    discard_next  = discard_cnt;

    if (instr_rvalid_i && (discard_cnt != '0)) discard_next = discard_cnt - CW'(1);

    unique case (state)
      IDLE: begin
        if (issue) begin
          state_next    = REQ;
          req_addr_next = fetch_addr;
        end
      end
      REQ: begin
        if (gnt_acc) begin
          fetch_next = fetch_addr + 32'd4;
          if (issue) begin
            state_next    = REQ;
            req_addr_next = fetch_addr + 32'd4;
          end else begin
            state_next = IDLE;
          end
        end
      end
      REQ_STALE: begin
        if (gnt_acc) begin
          discard_next = discard_next + CW'(1);
          if (issue) begin
            state_next    = REQ;
            req_addr_next = fetch_addr;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (branch_i) begin
      fetch_next    = branch_addr_i & FETCH_ALIGN_MASK;
      discard_next  = outstanding_after;
      req_addr_next = req_addr;
      state_next    = ((state != IDLE) && !gnt_acc) ? REQ_STALE : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fetch_addr  <= '0;
      req_addr    <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_next;
      fetch_addr  <= fetch_next;
      req_addr    <= req_addr_next;
      outstanding <= outstanding_after;
      discard_cnt <= discard_next;
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(instr_rvalid_i && (outstanding == '0)));
  end

  assign instr_req_o  = (state != IDLE);
  assign instr_addr_o = req_addr;
  assign fifo_clear_o = branch_i;
  assign fifo_valid_o = instr_rvalid_i && (discard_cnt == '0) && !branch_i;
  assign fifo_addr_o  = head_addr;
  assign fifo_rdata_o = instr_rdata_i;
  assign busy_o       = (state != IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_riscv_fetch_req_ctrl.sv
// Directed and randomized checks of the fetch request controller against a
// transaction-level model (pending request plus a queue of tagged in-flight fetches).
module tb_riscv_fetch_req_ctrl;

  localparam int MAXO = 2;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        fifo_in_ready_i = 1'b0;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        busy_o;

  int n_cmp = 0;
  int n_fail = 0;

  bit          m_pend;
  bit          m_stale;
  logic [31:0] m_pend_addr;
  logic [31:0] m_fetch;
  txn_t        m_q[$];

  riscv_fetch_req_ctrl #(
    .RDATA_WIDTH     (32),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_i           (req_i),
    .branch_i        (branch_i),
    .branch_addr_i   (branch_addr_i),
    .fifo_in_ready_i (fifo_in_ready_i),
    .fifo_clear_o    (fifo_clear_o),
    .fifo_valid_o    (fifo_valid_o),
    .fifo_addr_o     (fifo_addr_o),
    .fifo_rdata_o    (fifo_rdata_o),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_pend      = 1'b0;
    m_stale     = 1'b0;
    m_pend_addr = '0;
    m_fetch     = '0;
    m_q.delete();
  endtask

  task automatic checkOutput();
    bit exp_push;
    exp_push = instr_rvalid_i && (m_q.size() != 0) && !branch_i;
    if (exp_push) exp_push = !m_q[0].stale;
    cmp("instr_req", {31'd0, instr_req_o}, {31'd0, m_pend});
    if (m_pend) cmp("instr_addr", instr_addr_o, m_pend_addr);
    cmp("fifo_clear", {31'd0, fifo_clear_o}, {31'd0, branch_i});
    cmp("fifo_valid", {31'd0, fifo_valid_o}, {31'd0, exp_push});
    if (exp_push) begin
      cmp("fifo_addr", fifo_addr_o, m_q[0].addr);
      cmp("fifo_rdata", fifo_rdata_o, instr_rdata_i);
    end
    cmp("busy", {31'd0, busy_o}, {31'd0, (m_pend || m_q.size() != 0)});
  endtask

  // Advance the model across the coming clock edge using the inputs now driven.
  task automatic modelStep();
    bit granted;
    granted = m_pend && instr_gnt_i;
    if (instr_rvalid_i) void'(m_q.pop_front());
    if (granted) m_q.push_back('{addr: m_pend_addr, stale: m_stale});
    if (branch_i) begin
      foreach (m_q[i]) m_q[i].stale = 1'b1;
      m_fetch = branch_addr_i & ~32'h3;
      if (m_pend && !granted) m_stale = 1'b1;
      else m_pend = 1'b0;
    end else begin
      if (granted) begin
        if (!m_stale) m_fetch = m_fetch + 32'd4;
        m_pend = 1'b0;
      end
      if (!m_pend && req_i && fifo_in_ready_i && (m_q.size() < MAXO)) begin
        m_pend      = 1'b1;
        m_pend_addr = m_fetch;
        m_stale     = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit rq, input bit br, input logic [31:0] ba,
                               input bit rdy, input bit g, input bit rv);
    @(negedge clk);
    req_i           = rq;
    branch_i        = br;
    branch_addr_i   = ba;
    fifo_in_ready_i = rdy;
    instr_gnt_i     = g && m_pend;
    instr_rvalid_i  = rv && (m_q.size() != 0);
    instr_rdata_i   = $urandom;
    #1;
    checkOutput();
    modelStep();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n           = 1'b0;
    req_i           = 1'b0;
    branch_i        = 1'b0;
    branch_addr_i   = '0;
    fifo_in_ready_i = 1'b0;
    instr_gnt_i     = 1'b0;
    instr_rvalid_i  = 1'b0;
    #1;
    cmp("rst_instr_req", {31'd0, instr_req_o}, 32'd0);
    cmp("rst_instr_addr", instr_addr_o, 32'd0);
    cmp("rst_fifo_valid", {31'd0, fifo_valid_o}, 32'd0);
    cmp("rst_fifo_clear", {31'd0, fifo_clear_o}, 32'd0);
    cmp("rst_busy", {31'd0, busy_o}, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    doReset();

    // Streaming with a grant every cycle and responses one cycle later.
    applyStimulus(1, 0, 0, 1, 1, 1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1, 0, 0, 1, 1, 1);
      cmp("s1_addr", instr_addr_o, 32'(4 * k));
      if (k > 0) begin
        cmp("s1_push", {31'd0, fifo_valid_o}, 32'd1);
        cmp("s1_push_addr", fifo_addr_o, 32'(4 * (k - 1)));
      end
    end

    // Grant withheld: request at 0x4 must stay put.
    doReset();
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, 1, 0, 0);
      cmp("s2_req_held", {31'd0, instr_req_o}, 32'd1);
      cmp("s2_addr_held", instr_addr_o, 32'h4);
      cmp("s2_no_push", {31'd0, fifo_valid_o}, 32'd0);
    end
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1);

    // Two outstanding, then branch to an unaligned target.
    doReset();
    applyStimulus(1, 1, 32'h10, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 32'h203, 1, 0, 0);
    cmp("s3_clear", {31'd0, fifo_clear_o}, 32'd1);
    applyStimulus(1, 0, 0, 1, 0, 1);
    cmp("s3_drop0", {31'd0, fifo_valid_o}, 32'd0);
    applyStimulus(1, 0, 0, 1, 1, 1);
    cmp("s3_drop1", {31'd0, fifo_valid_o}, 32'd0);
    cmp("s3_new_req", instr_addr_o, 32'h200);
    applyStimulus(0, 0, 0, 1, 1, 1);
    cmp("s3_push", {31'd0, fifo_valid_o}, 32'd1);
    cmp("s3_push_addr", fifo_addr_o, 32'h200);
    applyStimulus(0, 0, 0, 1, 0, 1);

    // Branch while a request is still waiting for its grant.
    doReset();
    applyStimulus(1, 1, 32'h20, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h100, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    cmp("s4_stale_held", instr_addr_o, 32'h20);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    cmp("s4_redirect", instr_addr_o, 32'h100);
    cmp("s4_stale_drop", {31'd0, fifo_valid_o}, 32'd0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 1);
    cmp("s4_push_addr", fifo_addr_o, 32'h100);

    // FIFO back-pressure.
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      cmp("s5_no_req", {31'd0, instr_req_o}, 32'd0);
    end
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0);
    cmp("s5_resume", {31'd0, instr_req_o}, 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    cmp("s5_push_stalled", {31'd0, fifo_valid_o}, 32'd1);
    cmp("s5_idle", {31'd0, instr_req_o}, 32'd0);

    // Branch coinciding with a response and a grant.
    doReset();
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 1, 32'h300, 1, 1, 1);
    cmp("s6_drop_rvalid", {31'd0, fifo_valid_o}, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 1);
    cmp("s6_drop_granted", {31'd0, fifo_valid_o}, 32'd0);
    applyStimulus(0, 0, 0, 1, 1, 0);
    cmp("s6_redirect", instr_addr_o, 32'h300);
    applyStimulus(0, 0, 0, 1, 0, 1);
    cmp("s6_push_addr", fifo_addr_o, 32'h300);

    // Randomized traffic, including address wrap and a reset mid-stream.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ba;
      ba = (i % 5 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (i == 1500) doReset();
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0, ba,
                    $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
